// File: rtl/vc_input_port.sv
// vc_input_port: two-VC polarity-interleaved input port with per-VC FIFOs and XY route computation.
// Optional statistics counters (acc_cnt, drop_cnt) are enabled by defining VC_INPUT_STATS_EN.
module vc_input_port #(
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 4,
  parameter int HOP_W    = 8,
  parameter int VC_BIT   = 63,
  parameter int DIRX_BIT = 62,
  parameter int DIRY_BIT = 61,
  parameter int HOPX_LSB = 48,
  parameter int HOPY_LSB = 40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              polarity,
  input  logic              si,
  input  logic [DATA_W-1:0] datai,
  output logic              ri,
  output logic [4:0]        req,
  output logic [DATA_W-1:0] dout,
  input  logic              clear,
`ifdef VC_INPUT_STATS_EN
  output logic [15:0]       acc_cnt,
  output logic [7:0]        drop_cnt,
`endif
  output logic              err_vc
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [2][DEPTH];
  logic [1:0][AW:0]  wp, rp;
  logic              wvc, rvc, full_w, empty_r, wr, bad, pop;
  logic [DATA_W-1:0] h;
  logic [HOP_W-1:0]  hx, hy;
  assign wvc     = polarity;
  assign rvc     = ~polarity;
  assign full_w  = (wp[wvc] ^ rp[wvc]) == {1'b1, {AW{1'b0}}};
  assign empty_r = wp[rvc] == rp[rvc];
  assign ri      = ~reset & ~full_w;
  assign wr      = si & ri & (datai[VC_BIT] == wvc);
  assign bad     = si & ri & (datai[VC_BIT] != wvc);
  assign pop     = clear & (req != 5'd0);
  assign h       = mem[rvc][rp[rvc][AW-1:0]];
  assign hx      = h[HOPX_LSB+:HOP_W];
  assign hy      = h[HOPY_LSB+:HOP_W];
  // XY routing on the read-VC head: X hops first, then Y, then eject to PE
  always_comb begin
    req  = 5'd0;
    dout = '0;
    if (!empty_r) begin
      dout = h;
      if (hx != '0) begin
        req = h[DIRX_BIT] ? 5'b00010 : 5'b00001;
        dout[HOPX_LSB+:HOP_W] = hx - 1'b1;
      end else if (hy != '0) begin
        req = h[DIRY_BIT] ? 5'b01000 : 5'b00100;
        dout[HOPY_LSB+:HOP_W] = hy - 1'b1;
      end else begin
        req = 5'b10000;
      end
    end
  end
  // flit storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk)
    if (wr) mem[wvc][wp[wvc][AW-1:0]] <= datai;
  // FIFO pointers and the sticky VC-mismatch flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wp     <= '0;
      rp     <= '0;
      err_vc <= 1'b0;
    end else begin
      if (wr) wp[wvc] <= wp[wvc] + 1'b1;
      if (pop) rp[rvc] <= rp[rvc] + 1'b1;
      if (bad) err_vc <= 1'b1;
    end
  end
`ifdef VC_INPUT_STATS_EN
  // saturating accept/drop counters
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (wr && acc_cnt != 16'hFFFF) acc_cnt <= acc_cnt + 1'b1;
      if (bad && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_vc_input_port.sv
// tb_vc_input_port: directed self-checking bench for vc_input_port.
module tb_vc_input_port;
  logic        clk = 1'b0;
  logic        reset, polarity, si, clear;
  logic [63:0] datai;
  logic        ri, err_vc;
  logic [4:0]  req;
  logic [63:0] dout;
`ifdef VC_INPUT_STATS_EN
  logic [15:0] acc_cnt;
  logic [7:0]  drop_cnt;
`endif
  int n_chk = 0;
  int n_fail = 0;

  localparam logic [63:0] F1  = 64'h0002_0000_0000_00AA;
  localparam logic [63:0] F1O = 64'h0001_0000_0000_00AA;
  localparam logic [63:0] F2  = 64'hA000_0300_0000_0011;
  localparam logic [63:0] F2O = 64'hA000_0200_0000_0011;
  localparam logic [63:0] G   = 64'h0000_0000_0000_00B0;

  vc_input_port dut (
    .clk(clk), .reset(reset), .polarity(polarity), .si(si), .datai(datai),
    .ri(ri), .req(req), .dout(dout), .clear(clear),
`ifdef VC_INPUT_STATS_EN
    .acc_cnt(acc_cnt), .drop_cnt(drop_cnt),
`endif
    .err_vc(err_vc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic p, input logic s, input logic [63:0] d, input logic c);
    polarity = p;
    si = s;
    datai = d;
    clear = c;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 64'd0, 0);
    tick;
    tick;
    chk("rst_ri", 64'(ri), 64'd0);
    chk("rst_req", 64'(req), 64'd0);
    chk("rst_dout", dout, 64'd0);
    chk("rst_err", 64'(err_vc), 64'd0);
    reset = 1'b0;
    // single-flit routing: X east, then Y south with pop
    drive(0, 1, F1, 0);
    chk("t1_ri", 64'(ri), 64'd1);
    tick;
    drive(1, 1, F2, 0);
    chk("t1_req", 64'(req), 64'h01);
    chk("t1_dout", dout, F1O);
    tick;
    drive(0, 0, 64'd0, 1);
    chk("t2_req", 64'(req), 64'h08);
    chk("t2_dout", dout, F2O);
    tick;
    drive(1, 0, 64'd0, 1);
    chk("t2_vc0_req", 64'(req), 64'h01);
    tick;
    drive(0, 0, 64'd0, 0);
    chk("t2_vc1_empty", 64'(req), 64'd0);
    chk("t2_dout0", dout, 64'd0);
    tick;
    drive(1, 0, 64'd0, 0);
    chk("t2_vc0_empty", 64'(req), 64'd0);
    tick;
    // fill VC0 to DEPTH without popping
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, G + 64'(i), 0);
      chk("fill_ri", 64'(ri), 64'd1);
      tick;
      drive(1, 0, 64'd0, 0);
      chk("fill_head", dout, G);
      tick;
    end
    drive(0, 1, G + 64'd4, 0);
    chk("full_ri", 64'(ri), 64'd0);
    tick;
    drive(1, 0, 64'd0, 0);
    chk("other_ri", 64'(ri), 64'd1);
    tick;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 64'd0, 0);
      tick;
      drive(1, 0, 64'd0, 1);
      chk("drain_req", 64'(req), 64'h10);
      chk("drain_dout", dout, G + 64'(i));
      tick;
    end
    drive(0, 0, 64'd0, 0);
    tick;
    drive(1, 0, 64'd0, 0);
    chk("drain_empty", 64'(req), 64'd0);
    // VC0 flit offered while link writes VC1
    drive(1, 1, 64'h0000_0000_0000_00EE, 0);
    chk("err_ri", 64'(ri), 64'd1);
    tick;
    drive(0, 0, 64'd0, 0);
    chk("err_vc", 64'(err_vc), 64'd1);
    chk("err_not_stored", 64'(req), 64'd0);
`ifdef VC_INPUT_STATS_EN
    chk("drop_cnt", 64'(drop_cnt), 64'd1);
    chk("acc_cnt", 64'(acc_cnt), 64'd6);
`endif
    tick;
    // two flits per VC, popped alternately
    drive(0, 1, 64'h0000_0000_0000_00C0, 0);
    tick;
    drive(1, 1, 64'h8000_0000_0000_00D0, 0);
    tick;
    drive(0, 1, 64'h0000_0000_0000_00C1, 0);
    tick;
    drive(1, 1, 64'h8000_0000_0000_00D1, 0);
    tick;
    drive(0, 0, 64'd0, 1);
    chk("both_req0", 64'(req), 64'h10);
    chk("both_d0", dout, 64'h8000_0000_0000_00D0);
    tick;
    drive(1, 0, 64'd0, 1);
    chk("both_req1", 64'(req), 64'h10);
    chk("both_c0", dout, 64'h0000_0000_0000_00C0);
    tick;
    drive(0, 0, 64'd0, 1);
    chk("both_d1", dout, 64'h8000_0000_0000_00D1);
    tick;
    drive(1, 0, 64'd0, 1);
    chk("both_c1", dout, 64'h0000_0000_0000_00C1);
    tick;
    drive(0, 0, 64'd0, 0);
    chk("both_vc1_empty", 64'(req), 64'd0);
    tick;
    drive(1, 0, 64'd0, 0);
    chk("both_vc0_empty", 64'(req), 64'd0);
    chk("err_sticky", 64'(err_vc), 64'd1);
    tick;
    // reset with flits buffered
    drive(0, 1, 64'h0000_0000_0000_00E0, 0);
    tick;
    drive(1, 1, 64'h8000_0000_0000_00E1, 0);
    tick;
    drive(0, 1, 64'h0000_0000_0000_00E2, 0);
    tick;
    reset = 1'b1;
    drive(1, 0, 64'd0, 0);
    chk("mid_rst_ri", 64'(ri), 64'd0);
    tick;
    chk("mid_rst_req", 64'(req), 64'd0);
    chk("mid_rst_dout", dout, 64'd0);
    chk("mid_rst_err", 64'(err_vc), 64'd0);
    drive(0, 0, 64'd0, 0);
    chk("mid_rst_req1", 64'(req), 64'd0);
    tick;
    reset = 1'b0;
    drive(1, 0, 64'd0, 0);
    chk("post_rst_ri", 64'(ri), 64'd1);
    chk("post_rst_req0", 64'(req), 64'd0);
    chk("post_rst_dout", dout, 64'd0);
    tick;
    drive(0, 0, 64'd0, 0);
    chk("post_rst_req1", 64'(req), 64'd0);
    chk("post_rst_ri1", 64'(ri), 64'd1);
`ifdef VC_INPUT_STATS_EN
    chk("post_rst_acc", 64'(acc_cnt), 64'd0);
    chk("post_rst_drop", 64'(drop_cnt), 64'd0);
`endif
    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
